// File: rtl/fwd_hazard_unit_if.sv
// rtl/fwd_hazard_unit_if.sv - decode/issue/forwarding signal bundle for fwd_hazard_unit
interface fwd_hazard_unit_if #(
  parameter int AW     = 5,
  parameter int NSTG   = 3,
  parameter int MAXLAT = 4
);
  localparam int LW = $clog2(MAXLAT + 1);
  localparam int SW = $clog2(NSTG + 1);

  logic              flush;
  logic [AW-1:0]     id_rs1;
  logic [AW-1:0]     id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic              issue_valid;
  logic [AW-1:0]     issue_rd;
  logic              issue_wen;
  logic [LW-1:0]     issue_lat;
  logic [AW-1:0]     ex_rs1;
  logic [AW-1:0]     ex_rs2;
  logic [NSTG*AW-1:0] stg_rd;
  logic [NSTG-1:0]   stg_wen;
  logic [NSTG-1:0]   stg_ready;
  logic [SW-1:0]     frw_a;
  logic [SW-1:0]     frw_b;
  logic              id_stall;
  logic              ex_hazard;
  logic              busy;
  logic [15:0]       stall_cnt;

  modport slave (
    input  flush, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    input  issue_valid, issue_rd, issue_wen, issue_lat,
    input  ex_rs1, ex_rs2, stg_rd, stg_wen, stg_ready,
    output frw_a, frw_b, id_stall, ex_hazard, busy, stall_cnt
  );

  modport master (
    output flush, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    output issue_valid, issue_rd, issue_wen, issue_lat,
    output ex_rs1, ex_rs2, stg_rd, stg_wen, stg_ready,
    input  frw_a, frw_b, id_stall, ex_hazard, busy, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - EX operand forwarding select plus latency scoreboard for decode stalls
module fwd_hazard_unit #(
  parameter int AW     = 5,
  parameter int NSTG   = 3,
  parameter int MAXLAT = 4
) (
  input logic             clk,
  input logic             rst,
  fwd_hazard_unit_if.slave bus
);
  localparam int LW   = $clog2(MAXLAT + 1);
  localparam int SW   = $clog2(NSTG + 1);
  localparam int NREG = 1 << AW;
  localparam logic [LW-1:0] MAX_L = LW'(MAXLAT);

  logic [LW-1:0] sb [NREG];
  logic [LW-1:0] lat_clamped;
  logic          accept;
  logic          stall;
  logic          any_busy;
  logic [SW-1:0] sel_a;
  logic [SW-1:0] sel_b;
  logic          hazard;
  logic [15:0]   cnt;

  // Youngest stage wins: scan from oldest so lower indices overwrite.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = NSTG - 1; k >= 0; k--) begin
      if (bus.stg_wen[k] && bus.stg_rd[k*AW +: AW] != '0) begin
        if (bus.stg_rd[k*AW +: AW] == bus.ex_rs1) sel_a = SW'(k + 1);
        if (bus.stg_rd[k*AW +: AW] == bus.ex_rs2) sel_b = SW'(k + 1);
      end
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < NSTG; k++) begin
      if ((sel_a == SW'(k + 1) || sel_b == SW'(k + 1)) && !bus.stg_ready[k])
        hazard = 1'b1;
    end
  end

  always_comb begin
    stall = 1'b0;
    if (bus.id_rs1_used && bus.id_rs1 != '0 && sb[bus.id_rs1] != '0) stall = 1'b1;
    if (bus.id_rs2_used && bus.id_rs2 != '0 && sb[bus.id_rs2] != '0) stall = 1'b1;
  end

  always_comb begin
    any_busy = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      if (sb[r] != '0) any_busy = 1'b1;
    end
  end

  assign accept      = bus.issue_valid && !stall;
  assign lat_clamped = (bus.issue_lat > MAX_L) ? MAX_L : bus.issue_lat;

  // Entry 0 is held at zero so x0 can never look busy.
  always_ff @(posedge clk) begin
    sb[0] <= '0;
    for (int r = 1; r < NREG; r++) begin
      if (rst || bus.flush) begin
        sb[r] <= '0;
      end else if (accept && bus.issue_wen && bus.issue_rd == AW'(r)) begin
        sb[r] <= lat_clamped;
      end else if (sb[r] != '0) begin
        sb[r] <= sb[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (stall && cnt != 16'hFFFF) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign bus.frw_a     = sel_a;
  assign bus.frw_b     = sel_b;
  assign bus.ex_hazard = hazard;
  assign bus.id_stall  = stall;
  assign bus.busy      = any_busy;
  assign bus.stall_cnt = cnt;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - directed self-checking bench for fwd_hazard_unit
module tb_fwd_hazard_unit;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  fwd_hazard_unit_if #(.AW(5), .NSTG(3), .MAXLAT(4)) bus ();

  fwd_hazard_unit #(.AW(5), .NSTG(3), .MAXLAT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.flush       = 1'b0;
    bus.id_rs1      = '0;
    bus.id_rs2      = '0;
    bus.id_rs1_used = 1'b0;
    bus.id_rs2_used = 1'b0;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;
    bus.issue_wen   = 1'b0;
    bus.issue_lat   = '0;
    bus.ex_rs1      = '0;
    bus.ex_rs2      = '0;
    bus.stg_rd      = '0;
    bus.stg_wen     = '0;
    bus.stg_ready   = '1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic drive_issue(input logic [4:0] rd, input logic [2:0] lat);
    bus.issue_valid = 1'b1;
    bus.issue_wen   = 1'b1;
    bus.issue_rd    = rd;
    bus.issue_lat   = lat;
    bus.id_rs1_used = 1'b0;
    bus.id_rs2_used = 1'b0;
  endtask

  task automatic drive_dep(input logic [4:0] rs);
    bus.issue_valid = 1'b0;
    bus.id_rs1      = rs;
    bus.id_rs1_used = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
    checks++; if (bus.stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", bus.stall_cnt); end
    checks++; if (bus.id_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", bus.id_stall); end
  endtask

  task automatic test_forwarding();
    clear_inputs();
    bus.stg_rd  = {5'd0, 5'd5, 5'd5};
    bus.stg_wen = 3'b011;
    bus.ex_rs1  = 5'd5;
    #1;
    checks++; if (bus.frw_a !== 2'd1) begin failures++; $display("FAIL fwd_youngest got=%0d exp=1", bus.frw_a); end
    bus.stg_wen = 3'b010;
    #1;
    checks++; if (bus.frw_a !== 2'd2) begin failures++; $display("FAIL fwd_stage1 got=%0d exp=2", bus.frw_a); end
    bus.ex_rs1  = 5'd0;
    bus.stg_wen = 3'b111;
    #1;
    checks++; if (bus.frw_a !== 2'd0) begin failures++; $display("FAIL fwd_x0 got=%0d exp=0", bus.frw_a); end
    bus.stg_rd    = {5'd8, 5'd5, 5'd3};
    bus.stg_wen   = 3'b110;
    bus.ex_rs1    = 5'd3;
    bus.ex_rs2    = 5'd8;
    bus.stg_ready = 3'b101;
    #1;
    checks++; if (bus.frw_a !== 2'd0) begin failures++; $display("FAIL fwd_nowen got=%0d exp=0", bus.frw_a); end
    checks++; if (bus.frw_b !== 2'd3) begin failures++; $display("FAIL fwd_b_oldest got=%0d exp=3", bus.frw_b); end
    checks++; if (bus.ex_hazard !== 1'b0) begin failures++; $display("FAIL hazard_ready got=%0b exp=0", bus.ex_hazard); end
    bus.ex_rs1 = 5'd5;
    #1;
    checks++; if (bus.frw_a !== 2'd2) begin failures++; $display("FAIL fwd_a_stage1 got=%0d exp=2", bus.frw_a); end
    checks++; if (bus.ex_hazard !== 1'b1) begin failures++; $display("FAIL hazard_notready got=%0b exp=1", bus.ex_hazard); end
    clear_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    drive_issue(5'd7, 3'd1);
    tick();
    drive_dep(5'd7);
    #1;
    checks++; if (bus.id_stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%0b exp=1", bus.id_stall); end
    tick();
    checks++; if (bus.id_stall !== 1'b0) begin failures++; $display("FAIL lu_release got=%0b exp=0", bus.id_stall); end
    checks++; if (bus.stall_cnt !== 16'd1) begin failures++; $display("FAIL lu_cnt got=%0d exp=1", bus.stall_cnt); end
  endtask

  task automatic test_multi_cycle();
    int n;
    do_reset();
    drive_issue(5'd9, 3'd3);
    tick();
    drive_dep(5'd9);
    #1;
    checks++; if (bus.id_stall !== 1'b1 || bus.busy !== 1'b1) begin failures++; $display("FAIL lat3_start got stall=%0b busy=%0b exp 1 1", bus.id_stall, bus.busy); end
    tick();
    tick();
    checks++; if (bus.id_stall !== 1'b1) begin failures++; $display("FAIL lat3_third got=%0b exp=1", bus.id_stall); end
    tick();
    checks++; if (bus.id_stall !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL lat3_end got stall=%0b busy=%0b exp 0 0", bus.id_stall, bus.busy); end
    checks++; if (bus.stall_cnt !== 16'd3) begin failures++; $display("FAIL lat3_cnt got=%0d exp=3", bus.stall_cnt); end

    do_reset();
    drive_issue(5'd9, 3'd7);
    tick();
    drive_dep(5'd9);
    #1;
    n = 0;
    while (bus.id_stall === 1'b1 && n < 10) begin
      n++;
      tick();
    end
    checks++; if (n != 4) begin failures++; $display("FAIL clamp_cycles got=%0d exp=4", n); end
    checks++; if (bus.stall_cnt !== 16'd4) begin failures++; $display("FAIL clamp_cnt got=%0d exp=4", bus.stall_cnt); end
  endtask

  task automatic test_flush();
    do_reset();
    drive_issue(5'd9, 3'd4);
    tick();
    bus.issue_valid = 1'b0;
    tick();
    bus.flush = 1'b1;
    drive_issue(5'd10, 3'd2);
    tick();
    clear_inputs();
    bus.id_rs1      = 5'd9;
    bus.id_rs1_used = 1'b1;
    bus.id_rs2      = 5'd10;
    bus.id_rs2_used = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%0b exp=0", bus.busy); end
    checks++; if (bus.id_stall !== 1'b0) begin failures++; $display("FAIL flush_stall got=%0b exp=0", bus.id_stall); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_issue(5'd9, 3'd4);
    tick();
    drive_dep(5'd9);
    repeat (4) tick();
    drive_issue(5'd9, 3'd1);
    tick();
    drive_dep(5'd9);
    tick();
    drive_issue(5'd12, 3'd4);
    tick();
    bus.issue_valid = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b1 || bus.stall_cnt !== 16'd5) begin failures++; $display("FAIL pre_rst got busy=%0b cnt=%0d exp 1 5", bus.busy, bus.stall_cnt); end
    rst = 1'b1;
    bus.flush = 1'b1;
    drive_issue(5'd13, 3'd3);
    tick();
    rst = 1'b0;
    clear_inputs();
    bus.id_rs1      = 5'd12;
    bus.id_rs1_used = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.stall_cnt !== 16'd0) begin failures++; $display("FAIL post_rst got busy=%0b cnt=%0d exp 0 0", bus.busy, bus.stall_cnt); end
    checks++; if (bus.id_stall !== 1'b0) begin failures++; $display("FAIL post_rst_stall got=%0b exp=0", bus.id_stall); end
    drive_issue(5'd0, 3'd4);
    tick();
    bus.issue_valid = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rd0_busy got=%0b exp=0", bus.busy); end
  endtask

  task automatic sat_iter();
    drive_issue(5'd3, 3'd4);
    tick();
    drive_dep(5'd3);
    repeat (4) tick();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 16383; i++) sat_iter();
    checks++; if (bus.stall_cnt !== 16'd65532) begin failures++; $display("FAIL sat_mid got=%0d exp=65532", bus.stall_cnt); end
    sat_iter();
    sat_iter();
    checks++; if (bus.stall_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%0h exp=ffff", bus.stall_cnt); end
    checks++; if (bus.id_stall !== 1'b0) begin failures++; $display("FAIL sat_stall got=%0b exp=0", bus.id_stall); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    clear_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_multi_cycle();
    test_flush();
    test_reset_mid();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 SHALL have parameter AW, default 5, register-address width.
REQ-002 SHALL have parameter NSTG, default 3, number of forwarding source stages; index 0 is the youngest (EX/MEM), NSTG-1 the oldest.
REQ-003 SHALL have parameter MAXLAT, default 4, maximum result latency tracked; LW = clog2(MAXLAT+1), SW = clog2(NSTG+1).
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have port flush, input, 1, discards all pending scoreboard entries.
REQ-007 SHALL have ports id_rs1, id_rs2, input, AW each, decode-stage source registers; id_rs1_used, id_rs2_used, input, 1 each.
REQ-008 SHALL have ports issue_valid, input, 1; issue_rd, input, AW; issue_wen, input, 1; issue_lat, input, LW: instruction leaving decode and cycles until its result is forwardable.
REQ-009 SHALL have ports ex_rs1, ex_rs2, input, AW each, EX-stage source registers.
REQ-010 SHALL have ports stg_rd, input, NSTG*AW; stg_wen, input, NSTG; stg_ready, input, NSTG: destination, write-enable and result-valid per forwarding stage.
REQ-011 SHALL have ports frw_a, frw_b, output, SW each; 0 = register file, k = stage k-1.
REQ-012 SHALL have ports id_stall, output, 1; ex_hazard, output, 1; busy, output, 1; stall_cnt, output, 16.

Function
REQ-013 SHALL compute frw_a combinationally as k+1 for the lowest stage k with stg_wen[k], stg_rd[k] != 0, stg_rd[k] == ex_rs1; else 0. frw_b identical using ex_rs2.
REQ-014 SHALL assert ex_hazard combinationally when the stage selected by frw_a or frw_b has stg_ready = 0.
REQ-015 SHALL keep one LW-bit counter sb[r] per register r = 1..2^AW-1; sb[0] SHALL read as 0 permanently.
REQ-016 SHALL assert id_stall combinationally when (id_rs1_used and sb[id_rs1] != 0) or (id_rs2_used and sb[id_rs2] != 0); source x0 never stalls.
REQ-017 SHALL treat an issue as accepted only when issue_valid = 1 and id_stall = 0; otherwise issue inputs are ignored.
REQ-018 SHALL, each cycle, decrement every nonzero sb entry by 1; zero entries stay 0 (no wrap).
REQ-019 SHALL, on an accepted issue with issue_wen = 1 and issue_rd != 0, load sb[issue_rd] = min(issue_lat, MAXLAT) in place of that entry's decrement.
REQ-020 SHALL treat issue_lat = 0 as single-cycle ALU result: entry written 0, no stall generated.
REQ-021 SHALL, when flush = 1, clear all sb entries at the next edge; flush takes priority over a simultaneous issue.
REQ-022 SHALL drive busy = 1 when any sb entry is nonzero (registered state, combinational OR).
REQ-023 SHALL increment stall_cnt at each edge where id_stall = 1 and rst = 0; saturate at 16'hFFFF.
REQ-024 SHALL update state identically whether or not issue_valid is high apart from REQ-017/REQ-019 (decrement is free-running).

Reset
REQ-025 SHALL, when rst = 1 at a rising edge, clear all sb entries and stall_cnt to 0; rst takes priority over flush and issue.
REQ-026 SHALL therefore present id_stall = 0, busy = 0, stall_cnt = 0 in the cycle after reset; frw_a, frw_b, ex_hazard depend only on current inputs.
REQ-027 SHALL abandon any in-progress countdown on reset mid-operation; no stall carries over.

Verification
REQ-028 SHALL cover: stg_wen=3'b011, stg_rd[0]=stg_rd[1]=5, ex_rs1=5 -> frw_a=1; stg_wen=3'b010 -> frw_a=2; ex_rs1=0 -> frw_a=0.
REQ-029 SHALL cover load-use: accept issue rd=7 lat=1, next cycle id_rs1=7 used -> id_stall=1 exactly one cycle, stall_cnt=1, then id_stall=0.
REQ-030 SHALL cover lat=3 on rd=9 with dependent waiting -> id_stall high 3 cycles, busy falls with it, stall_cnt=3; issue_lat=7 clamps to MAXLAT=4 stall cycles.
REQ-031 SHALL cover flush with sb[9]=3 and simultaneous issue rd=10 lat=2 -> next cycle busy=0, no stall on 9 or 10.
REQ-032 SHALL cover rst asserted with sb entries pending and stall_cnt=5 -> next cycle busy=0, stall_cnt=0; issue_rd=0 lat=4 -> busy stays 0.
REQ-033 SHALL cover stall_cnt preload near saturation by holding a stall 65540 cycles (repeated lat=4 reissues) -> stall_cnt=16'hFFFF, no wrap; ex_hazard=1 when selected stage has stg_ready=0.
